vga_color_sequencer: RTL and testbench

- Generates the two 16-bit colour words (inner image, outer border) that the VGA timing/colour stage consumes as InImage_Color and OutImage_Color.
- Watches that stage's VGA_VS output, counts whole frames, and every FRAMES_PER_STEP frames advances either a fixed 8-entry palette or a grey triangle ramp.
- Colour changes are aligned to the start of vertical sync, so a frame is never drawn in two colours.

---
 rtl/vga_color_sequencer.sv | 117 +++++++++++
 tb/tb_vga_color_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/vga_color_sequencer.sv
// Frame-paced colour sequencer for the VGA timing stage: counts VS falling edges
// and every FRAMES_PER_STEP frames steps a fixed palette or a grey triangle ramp.
module vga_color_sequencer #(
  parameter int FRAMES_PER_STEP = 60,
  parameter int CNT_W           = 16
) (
  input  logic             pixel_clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             mode,
  input  logic             vga_vs,
  output logic [15:0]      InImage_Color,
  output logic [15:0]      OutImage_Color,
  output logic             step_pulse,
  output logic [CNT_W-1:0] frame_count
);

  // A period of 0 frames is treated as 1 so the terminal count never underflows.
  localparam int              LAST_INT = (FRAMES_PER_STEP < 1) ? 0 : FRAMES_PER_STEP - 1;
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(LAST_INT);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] COUNT = 1'b1;

  localparam logic RAMP_UP   = 1'b0;
  localparam logic RAMP_DOWN = 1'b1;

  function automatic logic [15:0] pal_color(input logic [2:0] idx);
    case (idx)
      3'd0:    pal_color = 16'hFFFF;
      3'd1:    pal_color = 16'h001F;
      3'd2:    pal_color = 16'hFC00;
      3'd3:    pal_color = 16'h03E0;
      3'd4:    pal_color = 16'h0000;
      3'd5:    pal_color = 16'hFC1F;
      3'd6:    pal_color = 16'hFFE0;
      default: pal_color = 16'h03FF;
    endcase
  endfunction

  logic [0:0] state;
  logic       vs_d;
  logic [2:0] pal_idx;
  logic [4:0] ramp_lvl;
  logic       ramp_dir;

  logic       tick;
  logic       count_en;
  logic       at_last;
  logic [2:0] pal_next;
  logic [4:0] ramp_next;
  logic       dir_next;
  logic [15:0] grey_word;

  always_comb begin
    tick      = vs_d & ~vga_vs;
    count_en  = (state == COUNT) && enable && tick;
    at_last   = (frame_count == LAST);
    pal_next  = pal_idx + 3'd1;
    ramp_next = ramp_lvl;
    dir_next  = ramp_dir;
    // The ramp bounces at both ends rather than repeating the end level.
    if (ramp_dir == RAMP_UP) begin
      if (ramp_lvl == 5'd31) begin
        ramp_next = 5'd30;
        dir_next  = RAMP_DOWN;
      end else begin
        ramp_next = ramp_lvl + 5'd1;
      end
    end else begin
      if (ramp_lvl == 5'd0) begin
        ramp_next = 5'd1;
        dir_next  = RAMP_UP;
      end else begin
        ramp_next = ramp_lvl - 5'd1;
      end
    end
    grey_word = {ramp_next, ramp_next[4], ramp_next, ramp_next};
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      state          <= IDLE;
      vs_d           <= 1'b0;
      frame_count    <= '0;
      pal_idx        <= 3'd0;
      ramp_lvl       <= 5'd0;
      ramp_dir       <= RAMP_UP;
      step_pulse     <= 1'b0;
      InImage_Color  <= 16'hFFFF;
      OutImage_Color <= 16'h0000;
    end else begin
      vs_d       <= vga_vs;
      state      <= enable ? COUNT : IDLE;
      step_pulse <= 1'b0;
      if (count_en) begin
        if (at_last) begin
          frame_count <= '0;
          step_pulse  <= 1'b1;
          if (mode) begin
            ramp_lvl       <= ramp_next;
            ramp_dir       <= dir_next;
            InImage_Color  <= grey_word;
            OutImage_Color <= ~grey_word;
          end else begin
            pal_idx        <= pal_next;
            InImage_Color  <= pal_color(pal_next);
            OutImage_Color <= pal_color(pal_next + 3'd4);
          end
        end else begin
          frame_count <= frame_count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_color_sequencer.sv
// Bench for vga_color_sequencer: two instances (3 and 1 frames per step) share
// stimulus and are compared each cycle against an arithmetic reference model.
module tb_vga_color_sequencer;

  logic pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  logic        reset, enable, mode, vga_vs;
  logic [15:0] in_a, out_a, in_b, out_b;
  logic        pulse_a, pulse_b;
  logic [15:0] fc_a, fc_b;

  vga_color_sequencer #(.FRAMES_PER_STEP(3), .CNT_W(16)) u_dut_a (
    .pixel_clk(pixel_clk), .reset(reset), .enable(enable), .mode(mode), .vga_vs(vga_vs),
    .InImage_Color(in_a), .OutImage_Color(out_a), .step_pulse(pulse_a), .frame_count(fc_a)
  );

  vga_color_sequencer #(.FRAMES_PER_STEP(1), .CNT_W(16)) u_dut_b (
    .pixel_clk(pixel_clk), .reset(reset), .enable(enable), .mode(mode), .vga_vs(vga_vs),
    .InImage_Color(in_b), .OutImage_Color(out_b), .step_pulse(pulse_b), .frame_count(fc_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  int          fps[2] = '{3, 1};
  int          m_fc[2], m_pal[2], m_ramp[2];
  logic [15:0] m_in[2], m_out[2];
  logic        m_pulse[2];
  logic        m_prev_vs, m_armed;
  logic [15:0] pal_tab[8] = '{16'hFFFF, 16'h001F, 16'hFC00, 16'h03E0,
                              16'h0000, 16'hFC1F, 16'hFFE0, 16'h03FF};
  logic        rnd_mode;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Triangle 0,1,..,31,30,..,1,0,1,.. indexed by the number of ramp steps taken.
  function automatic int tri_lvl(input int n);
    int p;
    p = n % 62;
    return (p <= 31) ? p : 62 - p;
  endfunction

  function automatic logic [15:0] grey(input int l);
    return 16'(l * 2048 + (l / 16) * 1024 + l * 32 + l);
  endfunction

  task automatic modelStep(input logic r, input logic e, input logic m, input logic v);
    logic tick;
    tick = m_prev_vs && !v;
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        m_fc[k] = 0; m_pal[k] = 0; m_ramp[k] = 0;
        m_in[k] = 16'hFFFF; m_out[k] = 16'h0000; m_pulse[k] = 1'b0;
      end else begin
        m_pulse[k] = 1'b0;
        if (m_armed && e && tick) begin
          if (m_fc[k] == fps[k] - 1) begin
            m_fc[k]    = 0;
            m_pulse[k] = 1'b1;
            if (m) begin
              m_ramp[k]++;
              m_in[k]  = grey(tri_lvl(m_ramp[k]));
              m_out[k] = ~m_in[k];
            end else begin
              m_pal[k] = (m_pal[k] + 1) % 8;
              m_in[k]  = pal_tab[m_pal[k]];
              m_out[k] = pal_tab[(m_pal[k] + 4) % 8];
            end
          end else begin
            m_fc[k]++;
          end
        end
      end
    end
    m_prev_vs = r ? 1'b0 : v;
    m_armed   = r ? 1'b0 : e;
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic m, input logic v);
    reset = r; enable = e; mode = m; vga_vs = v;
    modelStep(r, e, m, v);
    @(posedge pixel_clk);
    #1;
    checkOutput("in_a",    32'(in_a),    32'(m_in[0]));
    checkOutput("out_a",   32'(out_a),   32'(m_out[0]));
    checkOutput("pulse_a", 32'(pulse_a), 32'(m_pulse[0]));
    checkOutput("fc_a",    32'(fc_a),    32'(m_fc[0]));
    checkOutput("in_b",    32'(in_b),    32'(m_in[1]));
    checkOutput("out_b",   32'(out_b),   32'(m_out[1]));
    checkOutput("pulse_b", 32'(pulse_b), 32'(m_pulse[1]));
    checkOutput("fc_b",    32'(fc_b),    32'(m_fc[1]));
  endtask

  task automatic frameEdge(input logic e, input logic m);
    applyStimulus(1'b0, e, m, 1'b1);
    applyStimulus(1'b0, e, m, 1'b1);
    applyStimulus(1'b0, e, m, 1'b0);
    applyStimulus(1'b0, e, m, 1'b0);
  endtask

  logic [15:0] exp_pal_in[3]  = '{16'h001F, 16'hFC00, 16'h03E0};
  logic [15:0] exp_pal_out[3] = '{16'hFC1F, 16'hFFE0, 16'h03FF};

  initial begin
    reset = 1'b1; enable = 1'b1; mode = 1'b0; vga_vs = 1'b0;
    m_prev_vs = 1'b0; m_armed = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_fc[k] = 0; m_pal[k] = 0; m_ramp[k] = 0;
      m_in[k] = 16'hFFFF; m_out[k] = 16'h0000; m_pulse[k] = 1'b0;
    end
    @(posedge pixel_clk);
    #1;

    // Reset with VS low, then release: a low VS right after reset is not a tick.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("rst_in",    32'(in_a),    32'h0000FFFF);
    checkOutput("rst_out",   32'(out_a),   32'h00000000);
    checkOutput("rst_pulse", 32'(pulse_b), 32'h0);

    // Palette stepping every third frame.
    for (int s = 0; s < 3; s++) begin
      for (int f = 0; f < 3; f++) frameEdge(1'b1, 1'b0);
      checkOutput("pal_in",  32'(in_a),  32'(exp_pal_in[s]));
      checkOutput("pal_out", 32'(out_a), 32'(exp_pal_out[s]));
    end

    // Five more steps bring the palette back to white/black.
    for (int f = 0; f < 15; f++) frameEdge(1'b1, 1'b0);
    checkOutput("wrap_in",  32'(in_a),  32'h0000FFFF);
    checkOutput("wrap_out", 32'(out_a), 32'h00000000);

    // Ramp on the one-frame instance: 33 steps go up to 31 and back to 29.
    for (int f = 0; f < 33; f++) frameEdge(1'b1, 1'b1);
    checkOutput("ramp33_in", 32'(in_b), 32'h0000EFBD);

    // Disable after one edge: counter and colours freeze.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    frameEdge(1'b1, 1'b0);
    for (int f = 0; f < 5; f++) frameEdge(1'b0, 1'b0);
    checkOutput("dis_fc", 32'(fc_a), 32'h1);
    checkOutput("dis_in", 32'(in_a), 32'h0000FFFF);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    frameEdge(1'b1, 1'b0);
    checkOutput("reen_fc", 32'(fc_a), 32'h2);
    frameEdge(1'b1, 1'b0);
    checkOutput("reen_in", 32'(in_a), 32'h0000001F);

    // Reset lands on the cycle that would otherwise step.
    frameEdge(1'b1, 1'b0);
    frameEdge(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("rsttick_pulse", 32'(pulse_a), 32'h0);
    checkOutput("rsttick_in",    32'(in_a),    32'h0000FFFF);
    checkOutput("rsttick_fc",    32'(fc_a),    32'h0);

    // Randomised traffic across both modes, enables and occasional resets.
    rnd_mode = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 40) == 0) rnd_mode = ~rnd_mode;
      applyStimulus($urandom_range(0, 299) == 0, $urandom_range(0, 15) != 0,
                    rnd_mode, $urandom_range(0, 2) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
